// File: rtl/hdmi_rx_clk_detect.sv
// HDMI RX clock detector: measures TMDS/DIV against refclk, classifies it
// and sequences the RX PLL reset / lock handshake.
module hdmi_rx_clk_detect #(
    parameter int unsigned REFCLK_HZ      = 50000000,
    parameter int unsigned DIV            = 64,
    parameter int unsigned GATE_CYCLES    = 50000,
    parameter int unsigned TOL_SHIFT      = 4,
    parameter int unsigned STABLE_WINDOWS = 4,
    parameter int unsigned RST_CYCLES     = 64,
    parameter int unsigned LOCK_TIMEOUT   = 8
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        rx_clk_div,
    input  logic        pll_locked,
    output logic        pll_rst,
    output logic        freq_valid,
    output logic [2:0]  freq_code,
    output logic [15:0] meas_count,
    output logic        meas_strobe,
    output logic [3:0]  retry_cnt
);

    localparam logic [63:0] DEN  = 64'(REFCLK_HZ) * 64'(DIV);
    localparam logic [63:0] E1_L = (64'd25200000  * 64'(GATE_CYCLES)) / DEN;
    localparam logic [63:0] E2_L = (64'd74250000  * 64'(GATE_CYCLES)) / DEN;
    localparam logic [63:0] E3_L = (64'd148500000 * 64'(GATE_CYCLES)) / DEN;
    localparam logic [15:0] E1 = 16'(E1_L);
    localparam logic [15:0] E2 = 16'(E2_L);
    localparam logic [15:0] E3 = 16'(E3_L);
    localparam logic [15:0] T1 = E1 >> TOL_SHIFT;
    localparam logic [15:0] T2 = E2 >> TOL_SHIFT;
    localparam logic [15:0] T3 = E3 >> TOL_SHIFT;
    localparam logic [15:0] E1_HALF = E1 >> 1;

    localparam int GW = $clog2(GATE_CYCLES);
    localparam int RW = $clog2(RST_CYCLES) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int MW = $clog2(STABLE_WINDOWS + 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        PLL_RESET = 2'd1,
        WAIT_LOCK = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    function automatic logic near(input logic [15:0] c,
                                  input logic [15:0] e,
                                  input logic [15:0] t);
        logic [15:0] d;
        d = (c >= e) ? (c - e) : (e - c);
        return d <= t;
    endfunction

    function automatic logic [2:0] classify(input logic [15:0] c);
        if (near(c, E1, T1))   return 3'd1;
        if (near(c, E2, T2))   return 3'd2;
        if (near(c, E3, T3))   return 3'd3;
        if (c < E1_HALF)       return 3'd0;
        return 3'd7;
    endfunction

    logic [2:0]    rx_sync_q, rx_sync_d;
    logic [1:0]    lk_sync_q, lk_sync_d;
    logic [GW-1:0] gate_q, gate_d;
    logic [15:0]   edge_cnt_q, edge_cnt_d;
    logic [15:0]   meas_q, meas_d;
    logic [2:0]    code_q, code_d;
    logic          strobe_q, strobe_d;

    state_t        state_q, state_d;
    logic [MW-1:0] match_q, match_d;
    logic [2:0]    prev_q, prev_d;
    logic [2:0]    lat_q, lat_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [3:0]    retry_q, retry_d;

    logic        rx_edge;
    logic        locked_s;
    logic        code_ok;
    logic [15:0] edge_sum;

    assign rx_edge  = rx_sync_q[2] & ~rx_sync_q[1];
    assign locked_s = lk_sync_q[1];
    assign code_ok  = (code_q != 3'd0) && (code_q <= 3'd3);
    assign edge_sum = (edge_cnt_q == 16'hFFFF) ? 16'hFFFF
                                               : edge_cnt_q + 16'(rx_edge);

    always_comb begin
        rx_sync_d  = {rx_sync_q[1:0], rx_clk_div};
        lk_sync_d  = {lk_sync_q[0], pll_locked};
        gate_d     = gate_q + GW'(1);
        edge_cnt_d = edge_sum;
        meas_d     = meas_q;
        code_d     = code_q;
        strobe_d   = 1'b0;
        if (gate_q == GW'(GATE_CYCLES - 1)) begin
            gate_d     = '0;
            edge_cnt_d = '0;
            meas_d     = edge_sum;
            code_d     = classify(edge_sum);
            strobe_d   = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        prev_d    = prev_q;
        lat_d     = lat_q;
        rst_cnt_d = rst_cnt_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        unique case (state_q)
            SEARCH: begin
                if (strobe_q) begin
                    prev_d = code_q;
                    if (!code_ok)
                        match_d = '0;
                    else if (code_q == prev_q)
                        match_d = match_q + MW'(1);
                    else
                        match_d = MW'(1);
                    if (match_d == MW'(STABLE_WINDOWS)) begin
                        lat_d   = code_q;
                        state_d = PLL_RESET;
                    end
                end
            end
            PLL_RESET: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1))
                    state_d = WAIT_LOCK;
                else
                    rst_cnt_d = rst_cnt_q + RW'(1);
            end
            WAIT_LOCK: begin
                if (strobe_q && code_q != lat_q) begin
                    state_d = SEARCH;
                end else if (locked_s) begin
                    state_d = LOCKED;
                end else if (strobe_q) begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(LOCK_TIMEOUT)) begin
                        state_d = PLL_RESET;
                        if (retry_q != 4'hF)
                            retry_d = retry_q + 4'd1;
                    end
                end
            end
            LOCKED: begin
                if (strobe_q) begin
                    if (code_q != lat_q)
                        state_d = SEARCH;
                    else if (!locked_s)
                        state_d = PLL_RESET;
                end
            end
            default: state_d = SEARCH;
        endcase
        // every state starts with fresh per-state counters
        if (state_d != state_q) begin
            match_d   = '0;
            prev_d    = 3'd0;
            rst_cnt_d = '0;
            tmo_d     = '0;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= '0;
            lk_sync_q  <= '0;
            gate_q     <= '0;
            edge_cnt_q <= '0;
            meas_q     <= '0;
            code_q     <= '0;
            strobe_q   <= 1'b0;
            state_q    <= SEARCH;
            match_q    <= '0;
            prev_q     <= '0;
            lat_q      <= '0;
            rst_cnt_q  <= '0;
            tmo_q      <= '0;
            retry_q    <= '0;
        end else begin
            rx_sync_q  <= rx_sync_d;
            lk_sync_q  <= lk_sync_d;
            gate_q     <= gate_d;
            edge_cnt_q <= edge_cnt_d;
            meas_q     <= meas_d;
            code_q     <= code_d;
            strobe_q   <= strobe_d;
            state_q    <= state_d;
            match_q    <= match_d;
            prev_q     <= prev_d;
            lat_q      <= lat_d;
            rst_cnt_q  <= rst_cnt_d;
            tmo_q      <= tmo_d;
            retry_q    <= retry_d;
        end
    end

    assign pll_rst     = (state_q == SEARCH) || (state_q == PLL_RESET);
    assign freq_valid  = (state_q == LOCKED);
    assign freq_code   = (state_q == SEARCH) ? code_q : lat_q;
    assign meas_count  = meas_q;
    assign meas_strobe = strobe_q;
    assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_hdmi_rx_clk_detect.sv
// Directed bench for hdmi_rx_clk_detect with a 1000-cycle gate:
// expected counts 7 / 23 / 46 (tolerance 0 / 1 / 2).
`timescale 1ns/1ps
module tb_hdmi_rx_clk_detect;

    localparam int GATE = 1000;

    logic        refclk;
    logic        rst_n;
    logic        rx_clk_div;
    logic        pll_locked;
    logic        pll_rst;
    logic        freq_valid;
    logic [2:0]  freq_code;
    logic [15:0] meas_count;
    logic        meas_strobe;
    logic [3:0]  retry_cnt;

    int  n_vec = 0;
    int  n_err = 0;
    real rx_half = 0.0;
    bit  lock_en = 0;
    int  lk_cnt  = 0;

    hdmi_rx_clk_detect #(
        .GATE_CYCLES (GATE),
        .LOCK_TIMEOUT(2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .rx_clk_div (rx_clk_div),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .freq_valid (freq_valid),
        .freq_code  (freq_code),
        .meas_count (meas_count),
        .meas_strobe(meas_strobe),
        .retry_cnt  (retry_cnt)
    );

    initial begin
        refclk = 0;
        forever #10 refclk = ~refclk;
    end

    initial begin
        rx_clk_div = 0;
        forever begin
            if (rx_half == 0.0) begin
                rx_clk_div = 0;
                #10;
            end else begin
                #(rx_half) rx_clk_div = ~rx_clk_div;
            end
        end
    end

    // PLL model: locks 10 us (500 refclks) after reset release
    initial begin
        pll_locked = 0;
        forever begin
            @(negedge refclk);
            if (pll_rst || !lock_en) begin
                lk_cnt     = 0;
                pll_locked = 0;
            end else if (lk_cnt < 500) begin
                lk_cnt++;
            end else begin
                pll_locked = 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!meas_strobe && n < 2 * GATE + 10);
        if (!meas_strobe) chk({tag, "_tmo"}, 0, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge refclk);
    endtask

    initial begin
        int run;
        int n;
        rst_n = 0;
        cycles(5);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_valid", freq_valid, 0);
        chk("rst_code", freq_code, 0);
        chk("rst_count", meas_count, 0);
        chk("rst_strobe", meas_strobe, 0);
        chk("rst_retry", retry_cnt, 0);
        rst_n = 1;

        // no rx clock
        for (int i = 0; i < 3; i++) begin
            wait_strobe("noclk");
            chk("noclk_count", meas_count, 0);
            chk("noclk_code", freq_code, 0);
            chk("noclk_pll_rst", pll_rst, 1);
            chk("noclk_valid", freq_valid, 0);
        end

        // out-of-band frequency: ~13.3 edges per window
        rx_half = 750.0;
        wait_strobe("unk1");
        wait_strobe("unk2");
        chk("unk_count", (meas_count >= 13 && meas_count <= 14), 1);
        chk("unk_code", freq_code, 7);
        chk("unk_pll_rst", pll_rst, 1);

        // 148.5 MHz: 431 ns period, ~46.4 edges
        rx_half = 215.5;
        lock_en = 1;
        run = 0;
        n = 0;
        while (run < 4 && n < 10) begin
            wait_strobe("f148");
            n++;
            run = (freq_code == 3) ? run + 1 : 0;
        end
        chk("f148_stable", run, 4);
        chk("f148_count", (meas_count >= 44 && meas_count <= 48), 1);
        cycles(64);
        chk("f148_rst_hold", pll_rst, 1);
        cycles(1);
        chk("f148_rst_rel", pll_rst, 0);
        chk("f148_code", freq_code, 3);
        n = 0;
        while (!freq_valid && n < 3000) begin
            cycles(1);
            n++;
        end
        chk("f148_valid", freq_valid, 1);
        chk("f148_lock_rst", pll_rst, 0);
        chk("f148_lcode", freq_code, 3);
        chk("f148_retry", retry_cnt, 0);

        // switch to 74.25 MHz while locked
        wait_strobe("sw0");
        rx_half = 431.0;
        wait_strobe("sw1");
        chk("sw_count", (meas_count >= 22 && meas_count <= 24), 1);
        chk("sw_valid_pre", freq_valid, 1);
        cycles(1);
        chk("sw_valid", freq_valid, 0);
        chk("sw_pll_rst", pll_rst, 1);
        chk("sw_code", freq_code, 2);
        n = 0;
        while (!freq_valid && n < 10000) begin
            cycles(1);
            n++;
        end
        chk("f74_valid", freq_valid, 1);
        chk("f74_code", freq_code, 2);

        // lock loss and code change land on the same strobe
        wait_strobe("ll0");
        rx_half = 215.5;
        lock_en = 0;
        wait_strobe("ll1");
        chk("ll_valid_pre", freq_valid, 1);
        cycles(1);
        chk("ll_valid", freq_valid, 0);
        chk("ll_code", freq_code, 3);
        chk("ll_retry", retry_cnt, 0);
        cycles(100);
        chk("ll_search", pll_rst, 1);

        // lock never comes: retries every 2 windows, saturating at 15
        for (int k = 1; k <= 15; k++) begin
            n = 0;
            while (retry_cnt != 4'(k) && n < 8000) begin
                cycles(1);
                n++;
            end
            chk("retry_val", retry_cnt, k);
            chk("retry_pll_rst", pll_rst, 1);
        end
        cycles(5000);
        chk("retry_sat", retry_cnt, 15);
        chk("retry_novalid", freq_valid, 0);

        // async reset in WAIT_LOCK
        n = 0;
        while (pll_rst && n < 3000) begin
            cycles(1);
            n++;
        end
        chk("wl_entered", pll_rst, 0);
        #5 rst_n = 0;
        #2;
        chk("ar_pll_rst", pll_rst, 1);
        chk("ar_valid", freq_valid, 0);
        chk("ar_code", freq_code, 0);
        chk("ar_count", meas_count, 0);
        chk("ar_strobe", meas_strobe, 0);
        chk("ar_retry", retry_cnt, 0);
        cycles(2);
        rst_n = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
